// File: rtl/instruction_execute_stage_pkg.sv
// Shared constants, ALU operation enum and decode helpers for the MIPS EX stage.
package instruction_execute_stage_pkg;

    localparam int unsigned NB_DATA = 32;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    localparam logic [1:0] FW_WB  = 2'b01;
    localparam logic [1:0] FW_MEM = 2'b10;

    localparam logic [5:0] FUNC_SLL  = 6'b000000;
    localparam logic [5:0] FUNC_SRL  = 6'b000010;
    localparam logic [5:0] FUNC_SRA  = 6'b000011;
    localparam logic [5:0] FUNC_SLLV = 6'b000100;
    localparam logic [5:0] FUNC_SRLV = 6'b000110;
    localparam logic [5:0] FUNC_SRAV = 6'b000111;
    localparam logic [5:0] FUNC_JALR = 6'b001001;
    localparam logic [5:0] FUNC_ADD  = 6'b100000;
    localparam logic [5:0] FUNC_ADDU = 6'b100001;
    localparam logic [5:0] FUNC_SUB  = 6'b100010;
    localparam logic [5:0] FUNC_SUBU = 6'b100011;
    localparam logic [5:0] FUNC_AND  = 6'b100100;
    localparam logic [5:0] FUNC_OR   = 6'b100101;
    localparam logic [5:0] FUNC_XOR  = 6'b100110;
    localparam logic [5:0] FUNC_NOR  = 6'b100111;
    localparam logic [5:0] FUNC_SLT  = 6'b101010;
    localparam logic [5:0] FUNC_SLTU = 6'b101011;

    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    typedef enum logic [3:0] {
        AluZero, AluAdd, AluSub, AluAnd, AluOr, AluXor, AluNor, AluSlt,
        AluSltu, AluSll, AluSrl, AluSra, AluSllv, AluSrlv, AluSrav, AluPassB
    } alu_op_e;

    function automatic alu_op_e decode_rtype(input logic [5:0] func);
        case (func)
            FUNC_ADD, FUNC_ADDU: return AluAdd;
            FUNC_SUB, FUNC_SUBU: return AluSub;
            FUNC_AND:            return AluAnd;
            FUNC_OR:             return AluOr;
            FUNC_XOR:            return AluXor;
            FUNC_NOR:            return AluNor;
            FUNC_SLT:            return AluSlt;
            FUNC_SLTU:           return AluSltu;
            FUNC_SLL:            return AluSll;
            FUNC_SRL:            return AluSrl;
            FUNC_SRA:            return AluSra;
            FUNC_SLLV:           return AluSllv;
            FUNC_SRLV:           return AluSrlv;
            FUNC_SRAV:           return AluSrav;
            default:             return AluZero;  // includes JALR
        endcase
    endfunction

    function automatic alu_op_e decode_itype(input logic [5:0] opcode);
        case (opcode)
            OP_ADDI, OP_ADDIU: return AluAdd;
            OP_SLTI:           return AluSlt;
            OP_SLTIU:          return AluSltu;
            OP_ANDI:           return AluAnd;
            OP_ORI:            return AluOr;
            OP_XORI:           return AluXor;
            OP_LUI:            return AluPassB;
            default:           return AluZero;
        endcase
    endfunction

    function automatic logic [NB_DATA-1:0] fwd_sel(input logic [1:0] sel,
                                                   input logic [NB_DATA-1:0] reg_val,
                                                   input logic [NB_DATA-1:0] wb_val,
                                                   input logic [NB_DATA-1:0] mem_val);
        case (sel)
            FW_WB:   return wb_val;
            FW_MEM:  return mem_val;
            default: return reg_val;
        endcase
    endfunction

endpackage

// File: rtl/instruction_execute_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the EX stage; o_overflow exists only with
// EX_OVERFLOW_TRAP_EN defined.
interface instruction_execute_stage_if;
    import instruction_execute_stage_pkg::*;

    logic               i_stall, i_halt;
    logic [4:0]         i_rs, i_rt, i_rd, i_shamt;
    logic [NB_DATA-1:0] i_reg_DA, i_reg_DB, i_immediate, i_fwd_mem_data, i_fwd_wb_data;
    logic [5:0]         i_opcode, i_func;
    logic [15:0]        i_addr;
    logic               i_branch, i_jump, i_regDst, i_mem2Reg, i_memRead, i_memWrite;
    logic               i_regWrite, i_sign_flag, i_immediate_flag;
    logic [1:0]         i_aluSrc, i_aluOP, i_width, i_fw_a, i_fw_b;

    logic               o_mem2reg, o_memRead, o_memWrite, o_regWrite, o_jump, o_sign_flag;
    logic [1:0]         o_aluSrc, o_aluOP, o_width;
    logic [4:0]         o_write_reg;
    logic [NB_DATA-1:0] o_data4Mem, o_result;
`ifdef EX_OVERFLOW_TRAP_EN
    logic               o_overflow;
`endif

    modport master (
        output i_stall, i_halt, i_rs, i_rt, i_rd, i_shamt, i_reg_DA, i_reg_DB, i_immediate,
               i_fwd_mem_data, i_fwd_wb_data, i_opcode, i_func, i_addr, i_branch, i_jump,
               i_regDst, i_mem2Reg, i_memRead, i_memWrite, i_regWrite, i_sign_flag,
               i_immediate_flag, i_aluSrc, i_aluOP, i_width, i_fw_a, i_fw_b,
        input
`ifdef EX_OVERFLOW_TRAP_EN
               o_overflow,
`endif
               o_mem2reg, o_memRead, o_memWrite, o_regWrite, o_jump, o_sign_flag,
               o_aluSrc, o_aluOP, o_width, o_write_reg, o_data4Mem, o_result
    );

    modport slave (
        input  i_stall, i_halt, i_rs, i_rt, i_rd, i_shamt, i_reg_DA, i_reg_DB, i_immediate,
               i_fwd_mem_data, i_fwd_wb_data, i_opcode, i_func, i_addr, i_branch, i_jump,
               i_regDst, i_mem2Reg, i_memRead, i_memWrite, i_regWrite, i_sign_flag,
               i_immediate_flag, i_aluSrc, i_aluOP, i_width, i_fw_a, i_fw_b,
        output
`ifdef EX_OVERFLOW_TRAP_EN
               o_overflow,
`endif
               o_mem2reg, o_memRead, o_memWrite, o_regWrite, o_jump, o_sign_flag,
               o_aluSrc, o_aluOP, o_width, o_write_reg, o_data4Mem, o_result
    );

endinterface

// File: rtl/instruction_execute_stage_ex_alu.sv
// Combinational 32-bit ALU; overflow flags signed overflow of AluAdd/AluSub only.
module ex_alu
    import instruction_execute_stage_pkg::*;
(
    input  alu_op_e            i_op,
    input  logic [NB_DATA-1:0] i_a,
    input  logic [NB_DATA-1:0] i_b,
    input  logic [4:0]         i_shamt,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_overflow
);

    logic [NB_DATA-1:0] sum, diff;

    always_comb begin
        sum        = i_a + i_b;
        diff       = i_a - i_b;
        o_result   = '0;
        o_overflow = 1'b0;
        case (i_op)
            AluAdd: begin
                o_result   = sum;
                o_overflow = (i_a[31] == i_b[31]) && (sum[31] != i_a[31]);
            end
            AluSub: begin
                o_result   = diff;
                o_overflow = (i_a[31] != i_b[31]) && (diff[31] != i_a[31]);
            end
            AluAnd:   o_result = i_a & i_b;
            AluOr:    o_result = i_a | i_b;
            AluXor:   o_result = i_a ^ i_b;
            AluNor:   o_result = ~(i_a | i_b);
            AluSlt:   o_result = {31'b0, $signed(i_a) < $signed(i_b)};
            AluSltu:  o_result = {31'b0, i_a < i_b};
            AluSll:   o_result = i_b << i_shamt;
            AluSrl:   o_result = i_b >> i_shamt;
            AluSra:   o_result = $unsigned($signed(i_b) >>> i_shamt);
            AluSllv:  o_result = i_b << i_a[4:0];
            AluSrlv:  o_result = i_b >> i_a[4:0];
            AluSrav:  o_result = $unsigned($signed(i_b) >>> i_a[4:0]);
            AluPassB: o_result = i_b;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/instruction_execute_stage.sv
// MIPS EX stage: operand forwarding, ALU control decode, ALU and EX/MEM register.
// Define EX_OVERFLOW_TRAP_EN to add o_overflow and suppress regWrite on ADD/SUB/ADDI overflow.
module instruction_execute_stage
    import instruction_execute_stage_pkg::*;
(
    input logic                      clk,
    input logic                      i_rst,
    instruction_execute_stage_if.slave bus
);

    logic [NB_DATA-1:0] op_a, fwd_b, op_b, alu_result;
    logic [1:0]         mode;
    alu_op_e            alu_op;
    logic               alu_overflow;
    logic [4:0]         write_reg;
    logic               reg_write;
    logic               unused_ok;

    assign unused_ok = ^{bus.i_rs, bus.i_addr, bus.i_branch};

    always_comb begin
        op_a  = fwd_sel(bus.i_fw_a, bus.i_reg_DA, bus.i_fwd_wb_data, bus.i_fwd_mem_data);
        fwd_b = fwd_sel(bus.i_fw_b, bus.i_reg_DB, bus.i_fwd_wb_data, bus.i_fwd_mem_data);
        op_b  = fwd_b;
        if (bus.i_immediate_flag) begin
            case (bus.i_aluSrc)
                2'b00:   op_b = bus.i_immediate;
                2'b01:   op_b = {16'b0, bus.i_immediate[15:0]};
                default: op_b = {bus.i_immediate[15:0], 16'b0};
            endcase
        end
        // An immediate operand always implies opcode-driven decode
        mode = bus.i_immediate_flag ? ALUOP_ITYPE : bus.i_aluOP;
        case (mode)
            ALUOP_ADD:   alu_op = AluAdd;
            ALUOP_SUB:   alu_op = AluSub;
            ALUOP_RTYPE: alu_op = decode_rtype(bus.i_func);
            default:     alu_op = decode_itype(bus.i_opcode);
        endcase
        write_reg = bus.i_regDst ? bus.i_rd : bus.i_rt;
        if (bus.i_jump && bus.i_regWrite && !bus.i_regDst) write_reg = 5'd31;
    end

`ifdef EX_OVERFLOW_TRAP_EN
    logic trap;
    always_comb begin
        trap = alu_overflow &&
               (((mode == ALUOP_RTYPE) &&
                 (bus.i_func == FUNC_ADD || bus.i_func == FUNC_SUB)) ||
                ((mode == ALUOP_ITYPE) && (bus.i_opcode == OP_ADDI)));
        reg_write = bus.i_regWrite && !trap;
    end
`else
    logic unused_overflow;
    assign unused_overflow = alu_overflow;
    assign reg_write       = bus.i_regWrite;
`endif

    ex_alu u_alu (
        .i_op       (alu_op),
        .i_a        (op_a),
        .i_b        (op_b),
        .i_shamt    (bus.i_shamt),
        .o_result   (alu_result),
        .o_overflow (alu_overflow)
    );

    always_ff @(posedge clk) begin
        if (i_rst) begin
            bus.o_mem2reg   <= 1'b0;
            bus.o_memRead   <= 1'b0;
            bus.o_memWrite  <= 1'b0;
            bus.o_regWrite  <= 1'b0;
            bus.o_jump      <= 1'b0;
            bus.o_sign_flag <= 1'b0;
            bus.o_aluSrc    <= 2'b0;
            bus.o_aluOP     <= 2'b0;
            bus.o_width     <= 2'b0;
            bus.o_write_reg <= 5'b0;
            bus.o_data4Mem  <= '0;
            bus.o_result    <= '0;
`ifdef EX_OVERFLOW_TRAP_EN
            bus.o_overflow  <= 1'b0;
`endif
        end else if (!(bus.i_stall || bus.i_halt)) begin
            bus.o_mem2reg   <= bus.i_mem2Reg;
            bus.o_memRead   <= bus.i_memRead;
            bus.o_memWrite  <= bus.i_memWrite;
            bus.o_regWrite  <= reg_write;
            bus.o_jump      <= bus.i_jump;
            bus.o_sign_flag <= bus.i_sign_flag;
            bus.o_aluSrc    <= bus.i_aluSrc;
            bus.o_aluOP     <= bus.i_aluOP;
            bus.o_width     <= bus.i_width;
            bus.o_write_reg <= write_reg;
            bus.o_data4Mem  <= fwd_b;
            bus.o_result    <= alu_result;
`ifdef EX_OVERFLOW_TRAP_EN
            bus.o_overflow  <= trap;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_execute_stage.sv
// Directed and randomized checks of instruction_execute_stage against a behavioural model.
module tb_instruction_execute_stage;

    logic clk = 1'b0;
    logic i_rst;
    int   n_total = 0;
    int   n_bad   = 0;

    instruction_execute_stage_if bus ();

    instruction_execute_stage dut (
        .clk   (clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] exp_result, exp_d4m;
    logic [4:0]  exp_wr;
    logic [11:0] exp_ctrl;
    logic        exp_ovf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd_m(input logic [1:0] s, input logic [31:0] r);
        if (s == 2'd1) return bus.i_fwd_wb_data;
        if (s == 2'd2) return bus.i_fwd_mem_data;
        return r;
    endfunction

    // Reference: result from MIPS semantics, arithmetic done on wide integers
    task automatic model_update();
        logic [31:0] a, fb, b, r;
        logic [63:0] ext;
        longint      s;
        logic        ovf_applies, ovf;
        int          mode;
        a  = fwd_m(bus.i_fw_a, bus.i_reg_DA);
        fb = fwd_m(bus.i_fw_b, bus.i_reg_DB);
        if (!bus.i_immediate_flag)      b = fb;
        else if (bus.i_aluSrc == 2'd0)  b = bus.i_immediate;
        else if (bus.i_aluSrc == 2'd1)  b = {16'h0, bus.i_immediate[15:0]};
        else                            b = {bus.i_immediate[15:0], 16'h0};
        mode = bus.i_immediate_flag ? 3 : int'(bus.i_aluOP);
        r = 0;
        s = 0;
        ovf_applies = 1'b0;
        ext = {{32{b[31]}}, b};
        if (mode == 0) r = a + b;
        else if (mode == 1) r = a - b;
        else if (mode == 2) begin
            case (bus.i_func)
                6'h20, 6'h21: begin r = a + b; s = longint'($signed(a)) + longint'($signed(b));
                                    ovf_applies = (bus.i_func == 6'h20); end
                6'h22, 6'h23: begin r = a - b; s = longint'($signed(a)) - longint'($signed(b));
                                    ovf_applies = (bus.i_func == 6'h22); end
                6'h24: r = a & b;
                6'h25: r = a | b;
                6'h26: r = a ^ b;
                6'h27: r = ~(a | b);
                6'h2A: r = ($signed(a) < $signed(b)) ? 1 : 0;
                6'h2B: r = (a < b) ? 1 : 0;
                6'h00: r = b << bus.i_shamt;
                6'h02: r = b >> bus.i_shamt;
                6'h03: begin ext = ext >> bus.i_shamt; r = ext[31:0]; end
                6'h04: r = b << a[4:0];
                6'h06: r = b >> a[4:0];
                6'h07: begin ext = ext >> a[4:0]; r = ext[31:0]; end
                default: r = 0;
            endcase
        end else begin
            case (bus.i_opcode)
                6'h08, 6'h09: begin r = a + b; s = longint'($signed(a)) + longint'($signed(b));
                                    ovf_applies = (bus.i_opcode == 6'h08); end
                6'h0A: r = ($signed(a) < $signed(b)) ? 1 : 0;
                6'h0B: r = (a < b) ? 1 : 0;
                6'h0C: r = a & b;
                6'h0D: r = a | b;
                6'h0E: r = a ^ b;
                6'h0F: r = b;
                default: r = 0;
            endcase
        end
        ovf = ovf_applies && (s > 64'sd2147483647 || s < -64'sd2147483648);
        exp_result = r;
        exp_d4m    = fb;
        if (bus.i_jump && bus.i_regWrite && !bus.i_regDst) exp_wr = 5'd31;
        else exp_wr = bus.i_regDst ? bus.i_rd : bus.i_rt;
`ifdef EX_OVERFLOW_TRAP_EN
        exp_ovf = ovf;
`else
        exp_ovf = 1'b0;
        ovf     = 1'b0;
`endif
        exp_ctrl = {bus.i_mem2Reg, bus.i_memRead, bus.i_memWrite, bus.i_regWrite && !ovf,
                    bus.i_jump, bus.i_sign_flag, bus.i_aluSrc, bus.i_aluOP, bus.i_width};
    endtask

    task automatic step();
        if (i_rst) begin
            exp_result = 0; exp_d4m = 0; exp_wr = 0; exp_ctrl = 0; exp_ovf = 0;
        end else if (!(bus.i_stall || bus.i_halt)) begin
            model_update();
        end
        @(posedge clk);
        #1;
        check_eq("result", bus.o_result, exp_result);
        check_eq("data4Mem", bus.o_data4Mem, exp_d4m);
        check_eq("write_reg", {27'b0, bus.o_write_reg}, {27'b0, exp_wr});
        check_eq("ctrl", {20'b0, bus.o_mem2reg, bus.o_memRead, bus.o_memWrite, bus.o_regWrite,
                          bus.o_jump, bus.o_sign_flag, bus.o_aluSrc, bus.o_aluOP, bus.o_width},
                 {20'b0, exp_ctrl});
`ifdef EX_OVERFLOW_TRAP_EN
        check_eq("overflow", {31'b0, bus.o_overflow}, {31'b0, exp_ovf});
`endif
    endtask

    task automatic clear_inputs();
        i_rst = 0;
        bus.i_stall = 0; bus.i_halt = 0; bus.i_rs = 0; bus.i_rt = 0; bus.i_rd = 0;
        bus.i_shamt = 0; bus.i_reg_DA = 0; bus.i_reg_DB = 0; bus.i_immediate = 0;
        bus.i_fwd_mem_data = 0; bus.i_fwd_wb_data = 0; bus.i_opcode = 0; bus.i_func = 0;
        bus.i_addr = 0; bus.i_branch = 0; bus.i_jump = 0; bus.i_regDst = 0; bus.i_mem2Reg = 0;
        bus.i_memRead = 0; bus.i_memWrite = 0; bus.i_regWrite = 0; bus.i_sign_flag = 0;
        bus.i_immediate_flag = 0; bus.i_aluSrc = 0; bus.i_aluOP = 0; bus.i_width = 0;
        bus.i_fw_a = 0; bus.i_fw_b = 0;
    endtask

    logic [5:0] funcs [18] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                               6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h09, 6'h3F};
    logic [5:0] opcodes [9] = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23};

    function automatic logic [31:0] rnd_data();
        case ($urandom_range(0, 3))
            0:       return 32'h7FFF_FFF0 + $urandom_range(0, 31);
            1:       return 32'h8000_0000 + $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        clear_inputs();
        i_rst = 1;
        bus.i_reg_DA = 32'h1234; bus.i_aluOP = 2'b10; bus.i_func = 6'h20; bus.i_regWrite = 1;
        step();
        check_eq("reset_result", bus.o_result, 32'h0);
        clear_inputs();

        bus.i_reg_DA = 10; bus.i_reg_DB = 5; bus.i_aluOP = 2'b10; bus.i_func = 6'h20;
        step();
        check_eq("add_15", bus.o_result, 32'd15);

        clear_inputs();
        bus.i_immediate_flag = 1; bus.i_reg_DA = 32'hF0; bus.i_immediate = 32'hF;
        bus.i_opcode = 6'h08; bus.i_aluOP = 2'b11;
        step();
        check_eq("addi_ff", bus.o_result, 32'hFF);

        clear_inputs();
        bus.i_fw_a = 2'b10; bus.i_fwd_mem_data = 7; bus.i_reg_DA = 100; bus.i_reg_DB = 3;
        bus.i_aluOP = 2'b10; bus.i_func = 6'h22;
        step();
        check_eq("fwd_mem_sub", bus.o_result, 32'd4);

        bus.i_fw_b = 2'b01; bus.i_fwd_wb_data = 9;
        step();
        check_eq("fwd_wb_store", bus.o_data4Mem, 32'd9);
        check_eq("fwd_wb_sub", bus.o_result, 32'hFFFF_FFFE);

        bus.i_stall = 1; bus.i_reg_DA = 55; bus.i_fw_a = 0; bus.i_fw_b = 0; bus.i_regWrite = 1;
        step();
        check_eq("stall_hold", bus.o_result, 32'hFFFF_FFFE);
        bus.i_stall = 0; bus.i_halt = 1;
        step();
        check_eq("halt_hold", bus.o_data4Mem, 32'd9);
        bus.i_halt = 0;
        step();
        check_eq("release", bus.o_result, 32'd52);

        clear_inputs();
        bus.i_reg_DB = 32'h8000_0000; bus.i_shamt = 4; bus.i_aluOP = 2'b10; bus.i_func = 6'h03;
        step();
        check_eq("sra", bus.o_result, 32'hF800_0000);

        bus.i_reg_DA = 32'hFFFF_FFFF; bus.i_reg_DB = 1; bus.i_func = 6'h2A;
        step();
        check_eq("slt", bus.o_result, 32'd1);
        bus.i_func = 6'h2B;
        step();
        check_eq("sltu", bus.o_result, 32'd0);

        bus.i_jump = 1; bus.i_regWrite = 1; bus.i_rt = 5'd7; bus.i_func = 6'h09;
        step();
        check_eq("jal_r31", {27'b0, bus.o_write_reg}, 32'd31);
        check_eq("jalr_zero", bus.o_result, 32'd0);

        clear_inputs();
        bus.i_immediate_flag = 1; bus.i_aluSrc = 2'b10; bus.i_immediate = 32'h0000_ABCD;
        bus.i_opcode = 6'h0F;
        step();
        check_eq("lui", bus.o_result, 32'hABCD_0000);

        for (int n = 0; n < 600; n++) begin
            i_rst = ($urandom_range(0, 39) == 0);
            bus.i_stall = ($urandom_range(0, 6) == 0);
            bus.i_halt = ($urandom_range(0, 9) == 0);
            bus.i_rs = 5'($urandom); bus.i_rt = 5'($urandom); bus.i_rd = 5'($urandom);
            bus.i_shamt = 5'($urandom);
            bus.i_reg_DA = rnd_data(); bus.i_reg_DB = rnd_data();
            bus.i_immediate = rnd_data(); bus.i_fwd_mem_data = rnd_data();
            bus.i_fwd_wb_data = rnd_data();
            bus.i_func = funcs[$urandom_range(0, 17)];
            bus.i_opcode = opcodes[$urandom_range(0, 8)];
            bus.i_addr = 16'($urandom); bus.i_branch = 1'($urandom);
            bus.i_jump = 1'($urandom); bus.i_regDst = 1'($urandom);
            bus.i_mem2Reg = 1'($urandom); bus.i_memRead = 1'($urandom);
            bus.i_memWrite = 1'($urandom); bus.i_regWrite = 1'($urandom);
            bus.i_sign_flag = 1'($urandom); bus.i_immediate_flag = 1'($urandom);
            bus.i_aluSrc = 2'($urandom); bus.i_aluOP = 2'($urandom); bus.i_width = 2'($urandom);
            bus.i_fw_a = 2'($urandom); bus.i_fw_b = 2'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
